// File: rtl/modbus_frame_tx.sv
// Modbus RTU response-frame transmitter: serialises a latched reply plus CRC-16 through a
// byte UART, then holds off for the 3.5-character inter-frame silence.
//
// state | meaning
// IDLE  | waiting for an accepted response request
// LOAD  | present byte[idx] to the UART and start its CRC fold
// WAIT  | fold CRC one bit per cycle while the UART shifts the byte out
// GUARD | inter-frame silence down-counter
module modbus_frame_tx #(
  parameter int unsigned CLK_FREQ  = 32'd50000000,
  parameter int unsigned BAUD_RATE = 32'd115200,
  parameter logic [7:0]  ADDR      = 8'h01
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        tx_req,
  input  logic [1:0]  resp_type,
  input  logic [7:0]  func_code,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic [7:0]  exc_code,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned GUARD_CYC  = (CLK_FREQ / BAUD_RATE) * 77 / 2;
  localparam int unsigned GW         = (GUARD_CYC > 2) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WAIT  = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    type_q, type_d;
  logic [7:0]    func_q, func_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [7:0]    exc_q, exc_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   crc_q, crc_d;
  logic [3:0]    fold_q, fold_d;
  logic          done_seen_q, done_seen_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          tx_start_d;
  logic [7:0]    tx_data_d;
  logic          busy_d;
  logic          frame_done_d;

  logic [3:0]    frame_len;
  logic [3:0]    idx_ext;
  logic [7:0]    cur_byte;

  function automatic logic [15:0] crc_step(input logic [15:0] c);
    logic [15:0] s;
    s = {1'b0, c[15:1]};
    if (c[0]) s = s ^ 16'hA001;
    return s;
  endfunction

  always_comb begin
    frame_len = 4'd5;
    case (type_q)
      2'd0:    frame_len = 4'd7;
      2'd1:    frame_len = 4'd8;
      default: frame_len = 4'd5;
    endcase
  end

  assign idx_ext = {1'b0, idx_q};

  // CRC bytes are taken straight from the running CRC; the fold of the last payload
  // byte has always finished before LOAD is re-entered.
  always_comb begin
    cur_byte = 8'h00;
    if (idx_ext == frame_len - 4'd2) begin
      cur_byte = crc_q[7:0];
    end else if (idx_ext == frame_len - 4'd1) begin
      cur_byte = crc_q[15:8];
    end else if (idx_q == 3'd0) begin
      cur_byte = ADDR;
    end else begin
      case (type_q)
        2'd0: begin
          case (idx_q)
            3'd1:    cur_byte = func_q;
            3'd2:    cur_byte = 8'h02;
            3'd3:    cur_byte = data_q[15:8];
            3'd4:    cur_byte = data_q[7:0];
            default: cur_byte = 8'h00;
          endcase
        end
        2'd1: begin
          case (idx_q)
            3'd1:    cur_byte = func_q;
            3'd2:    cur_byte = addr_q[15:8];
            3'd3:    cur_byte = addr_q[7:0];
            3'd4:    cur_byte = data_q[15:8];
            3'd5:    cur_byte = data_q[7:0];
            default: cur_byte = 8'h00;
          endcase
        end
        default: begin
          case (idx_q)
            3'd1:    cur_byte = func_q | 8'h80;
            3'd2:    cur_byte = exc_q;
            default: cur_byte = 8'h00;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    func_d       = func_q;
    addr_d       = addr_q;
    data_d       = data_q;
    exc_d        = exc_q;
    idx_d        = idx_q;
    crc_d        = crc_q;
    fold_d       = fold_q;
    done_seen_d  = done_seen_q;
    guard_d      = guard_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data;
    busy_d       = busy;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        // frame_done still high means the guard just expired this cycle; hold off one cycle
        if (tx_req && (resp_type != 2'd3) && !frame_done) begin
          type_d      = resp_type;
          func_d      = func_code;
          addr_d      = addr;
          data_d      = data;
          exc_d       = exc_code;
          idx_d       = 3'd0;
          crc_d       = 16'hFFFF;
          fold_d      = 4'd0;
          done_seen_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tx_start_d  = 1'b1;
        tx_data_d   = cur_byte;
        done_seen_d = 1'b0;
        if (idx_ext < frame_len - 4'd2) begin
          crc_d  = crc_q ^ {8'h00, cur_byte};
          fold_d = 4'd8;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (fold_q != 4'd0) begin
          crc_d  = crc_step(crc_q);
          fold_d = fold_q - 4'd1;
        end
        if ((tx_done || done_seen_q) && (fold_q == 4'd0)) begin
          done_seen_d = 1'b0;
          if (idx_ext + 4'd1 < frame_len) begin
            idx_d   = idx_q + 3'd1;
            state_d = LOAD;
          end else begin
            guard_d = GUARD_LOAD;
            state_d = GUARD;
          end
        end else if (tx_done) begin
          done_seen_d = 1'b1;
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else begin
          guard_d = guard_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      type_q      <= 2'd0;
      func_q      <= 8'h00;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      exc_q       <= 8'h00;
      idx_q       <= 3'd0;
      crc_q       <= 16'h0000;
      fold_q      <= 4'd0;
      done_seen_q <= 1'b0;
      guard_q     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      func_q      <= func_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      exc_q       <= exc_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      fold_q      <= fold_d;
      done_seen_q <= done_seen_d;
      guard_q     <= guard_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      busy        <= busy_d;
      frame_done  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_modbus_frame_tx.sv
// Bench for modbus_frame_tx: table vectors, random replies against a byte-level frame/CRC
// model, and hand-written request-collision and reset sequences. Emulates uart_byte_tx.
module tb_modbus_frame_tx;

  localparam int unsigned CLK_F = 2000000;
  localparam int unsigned BAUD  = 115200;
  localparam logic [7:0]  SADDR = 8'h01;
  localparam int          G     = (CLK_F / BAUD) * 77 / 2;

  typedef logic [0:7][7:0] frame_t;
  typedef struct packed {
    logic [1:0]  rt;
    logic [7:0]  fc;
    logic [15:0] ad;
    logic [15:0] dt;
    logic [7:0]  ex;
    int          n;
    frame_t      b;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        tx_req;
  logic [1:0]  resp_type;
  logic [7:0]  func_code;
  logic [15:0] addr;
  logic [15:0] data;
  logic [7:0]  exc_code;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] frame_q[$];
  int n_starts = 0;
  int n_unstable = 0;
  int n_gap_bad = 0;
  int last_done_cyc = 0;
  int stray_done = 0;
  int stray_req = 0;
  int frame_base = 0;
  int cur_n = 8;
  int starts_base = 0;
  bit strict = 1'b1;
  bit dly_mode = 1'b0;

  vec_t vecs [3];

  modbus_frame_tx #(.CLK_FREQ(CLK_F), .BAUD_RATE(BAUD), .ADDR(SADDR)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .tx_req(tx_req), .resp_type(resp_type),
    .func_code(func_code), .addr(addr), .data(data), .exc_code(exc_code),
    .tx_done(tx_done), .tx_start(tx_start), .tx_data(tx_data), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input frame_t f, input int len);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {8'h00, f[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic int model_len(input logic [1:0] rt);
    return (rt == 2'd0) ? 7 : (rt == 2'd1) ? 8 : 5;
  endfunction

  function automatic frame_t model_frame(input logic [1:0] rt, input logic [7:0] fc,
                                         input logic [15:0] ad, input logic [15:0] dt,
                                         input logic [7:0] ex);
    frame_t f = '0;
    logic [15:0] c;
    int n = model_len(rt);
    f[0] = SADDR;
    if (rt == 2'd0) begin
      f[1] = fc; f[2] = 8'h02; f[3] = dt[15:8]; f[4] = dt[7:0];
    end else if (rt == 2'd1) begin
      f[1] = fc; f[2] = ad[15:8]; f[3] = ad[7:0]; f[4] = dt[15:8]; f[5] = dt[7:0];
    end else begin
      f[1] = fc | 8'h80; f[2] = ex;
    end
    c = crc16(f, n - 2);
    f[n-2] = c[7:0];
    f[n-1] = c[15:8];
    return f;
  endfunction

  // uart_byte_tx stand-in: byte time is short and sometimes shorter than the CRC fold
  initial begin
    int pos, d, g, exp_gap;
    logic [7:0] cap;
    tx_done = 1'b0;
    forever begin
      @(negedge clk_in);
      if (stray_done < stray_req) begin
        tx_done = 1'b1;
        @(negedge clk_in);
        tx_done = 1'b0;
        stray_done++;
      end
      while (tx_start) begin
        pos = frame_q.size() - frame_base;
        cap = tx_data;
        frame_q.push_back(tx_data);
        n_starts++;
        d = dly_mode ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 24));
        for (int i = 0; i < d; i++) begin
          @(negedge clk_in);
          if (strict && (tx_data !== cap || tx_start)) n_unstable++;
        end
        tx_done = 1'b1;
        last_done_cyc = cyc;
        g = 0;
        do begin
          @(negedge clk_in);
          g++;
          if (g == 1) tx_done = 1'b0;
        end while (!tx_start && g < 40);
        exp_gap = (pos < cur_n - 2 && d < 8) ? (10 - d) : 2;
        if (strict) begin
          if (tx_start && pos + 1 >= cur_n) n_gap_bad++;
          else if (tx_start && g != exp_gap) n_gap_bad++;
          else if (!tx_start && pos + 1 < cur_n) n_gap_bad++;
        end
      end
    end
  end

  task automatic begin_frame(input int n);
    frame_base  = frame_q.size();
    starts_base = n_starts;
    cur_n       = n;
  endtask

  task automatic drive_inputs(input vec_t v);
    resp_type = v.rt; func_code = v.fc; addr = v.ad; data = v.dt; exc_code = v.ex;
  endtask

  task automatic scramble();
    resp_type = 2'($urandom); func_code = 8'($urandom); addr = 16'($urandom);
    data = 16'($urandom); exc_code = 8'($urandom);
  endtask

  task automatic start_req(input vec_t v);
    @(negedge clk_in);
    drive_inputs(v);
    tx_req = 1'b1;
    @(negedge clk_in);
    tx_req = 1'b0;
    scramble();
    check("busy_after_req", busy, 1);
    check("no_early_start", tx_start, 0);
    @(negedge clk_in);
    check("first_start", tx_start, 1);
  endtask

  task automatic wait_bytes(input int nb);
    int k = 0;
    while ((frame_q.size() - frame_base) < nb && k < 3000) begin
      @(negedge clk_in);
      k++;
    end
    check("bytes_reached", ((frame_q.size() - frame_base) >= nb), 1);
  endtask

  task automatic finish_frame(input vec_t v, input string tag);
    int k = 0;
    frame_t got = '0;
    int nb;
    while (!frame_done && k < 5000) begin
      @(negedge clk_in);
      k++;
    end
    check({tag, "_frame_done"}, frame_done, 1);
    check({tag, "_guard_len"}, cyc - last_done_cyc, G + 1);
    check({tag, "_busy_low"}, busy, 0);
    nb = frame_q.size() - frame_base;
    check({tag, "_nbytes"}, nb, v.n);
    check({tag, "_nstarts"}, n_starts - starts_base, v.n);
    for (int i = 0; i < v.n && i < 8; i++) begin
      if (i < nb) got[i] = frame_q[frame_base + i];
      check($sformatf("%s_byte%0d", tag, i), (i < nb) ? {24'h0, got[i]} : 32'hDEAD, v.b[i]);
    end
    check({tag, "_crc_loopback"}, crc16(got, v.n), 0);
    check({tag, "_tx_data_stable"}, n_unstable, 0);
    check({tag, "_start_spacing"}, n_gap_bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    begin_frame(v.n);
    start_req(v);
    finish_frame(v, tag);
    @(negedge clk_in);
    check({tag, "_fd_one_pulse"}, frame_done, 0);
  endtask

  initial begin
    vec_t rv, alt;
    int s;
    bit busy_seen;
    rst_n_in = 1'b0;
    tx_req = 1'b0;
    resp_type = 2'd0; func_code = 8'h00; addr = 16'h0000; data = 16'h0000; exc_code = 8'h00;

    vecs[0] = '0;
    vecs[0].rt = 2'd1; vecs[0].fc = 8'h06; vecs[0].ad = 16'h0001; vecs[0].dt = 16'h0005;
    vecs[0].n = 8;
    vecs[0].b = {8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h05, 8'h18, 8'h09};
    vecs[1] = '0;
    vecs[1].rt = 2'd2; vecs[1].fc = 8'h03; vecs[1].ex = 8'h02; vecs[1].n = 5;
    vecs[1].b = {8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1, 8'h00, 8'h00, 8'h00};
    vecs[2] = '0;
    vecs[2].rt = 2'd0; vecs[2].fc = 8'h03; vecs[2].dt = 16'h0005; vecs[2].n = 7;
    vecs[2].b = model_frame(2'd0, 8'h03, 16'h0000, 16'h0005, 8'h00);

    repeat (3) @(negedge clk_in);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    for (int v = 0; v < 3; v++) begin
      dly_mode = (v == 1);
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 4; r++) begin
      rv = '0;
      rv.rt = 2'($urandom_range(0, 2));
      rv.fc = 8'($urandom); rv.ad = 16'($urandom); rv.dt = 16'($urandom); rv.ex = 8'($urandom);
      rv.n = model_len(rv.rt);
      rv.b = model_frame(rv.rt, rv.fc, rv.ad, rv.dt, rv.ex);
      dly_mode = ($urandom_range(0, 1) == 1);
      run_vec(rv, $sformatf("rnd%0d", r));
    end

    // reserved type and stray tx_done while idle
    dly_mode = 1'b0;
    s = n_starts;
    busy_seen = 1'b0;
    @(negedge clk_in);
    resp_type = 2'd3; func_code = 8'h03; tx_req = 1'b1;
    @(negedge clk_in);
    tx_req = 1'b0;
    stray_req = stray_req + 3;
    repeat (40) begin
      @(negedge clk_in);
      if (busy) busy_seen = 1'b1;
    end
    check("rt3_busy", busy_seen, 0);
    check("rt3_stray_starts", n_starts - s, 0);

    // requests mid-frame and in guard are dropped, then one in the frame_done cycle
    alt = vecs[2];
    begin_frame(8);
    start_req(vecs[0]);
    wait_bytes(3);
    @(negedge clk_in);
    alt.rt = 2'd2; drive_inputs(alt); tx_req = 1'b1;
    @(negedge clk_in);
    tx_req = 1'b0;
    wait_bytes(8);
    repeat (60) @(negedge clk_in);
    check("busy_in_guard", busy, 1);
    alt.rt = 2'd0; drive_inputs(alt); tx_req = 1'b1;
    @(negedge clk_in);
    tx_req = 1'b0;
    finish_frame(vecs[0], "collide");
    drive_inputs(vecs[1]);
    tx_req = 1'b1;
    begin_frame(5);
    @(negedge clk_in);
    check("req_on_fd_ignored", busy, 0);
    @(negedge clk_in);
    tx_req = 1'b0;
    scramble();
    check("req_after_fd", busy, 1);
    @(negedge clk_in);
    check("after_fd_first_start", tx_start, 1);
    finish_frame(vecs[1], "after_fd");
    @(negedge clk_in);

    // reset during byte 3 of a write echo
    begin_frame(8);
    start_req(vecs[0]);
    wait_bytes(4);
    strict = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    s = n_starts;
    busy_seen = 1'b0;
    repeat (100) begin
      @(negedge clk_in);
      if (busy) busy_seen = 1'b1;
    end
    check("post_rst_no_start", n_starts - s, 0);
    check("post_rst_busy", busy_seen, 0);
    strict = 1'b1;
    run_vec(vecs[1], "post_rst_exc");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modbus_frame_tx.md
# modbus_frame_tx

Modbus RTU response-frame transmitter for the slave. It accepts a response request from the slave's command logic after `frame_rx` and `modbus_crc` have validated a request. It serialises address, function, payload and an inline-computed CRC-16 through `uart_byte_tx` one byte at a time, then enforces the 3.5-character inter-frame silence before accepting the next response.

## Interface
- `CLK_FREQ`, 'd50000000, system clock frequency in Hz
- `BAUD_RATE`, 'd115200, UART bit rate
- `ADDR`, 8'h01, slave address placed in byte 0 of every frame
- `clk_in`  input  1  system clock; the only clock
- `rst_n_in`  input  1  reset, synchronous, active-low
- `tx_req`  input  1  one-cycle request pulse; sampled only in IDLE
- `resp_type`  input  2  0 = read-register reply, 1 = write echo, 2 = exception, 3 = reserved
- `func_code`  input  8  function code of the request being answered
- `addr`  input  16  register address (write echo)
- `data`  input  16  register value (read reply, write echo)
- `exc_code`  input  8  exception code (exception frame)
- `tx_done`  input  1  byte-complete pulse from `uart_byte_tx`
- `tx_start`  output  1  one-cycle start pulse to `uart_byte_tx`
- `tx_data`  output  8  byte to transmit
- `busy`  output  1  high from request acceptance until the end of the guard interval
- `frame_done`  output  1  one-cycle pulse when the guard interval expires

## Operation
- Frame content is fixed by `resp_type`, with N bytes total including the 2 CRC bytes:
  - type 0 (N = 7): ADDR, func_code, 8'h02, data[15:8], data[7:0], CRClo, CRChi.
  - type 1 (N = 8): ADDR, func_code, addr[15:8], addr[7:0], data[15:8], data[7:0], CRClo, CRChi.
  - type 2 (N = 5): ADDR, func_code | 8'h80, exc_code, CRClo, CRChi.
  - type 3: request ignored; no frame is sent and `busy` stays low.
- All inputs are latched on acceptance. Later changes to the inputs do not affect the frame in flight.
- CRC-16/Modbus:
  - init 16'hFFFF, reflected polynomial 16'hA001.
  - Per byte: XOR the byte into crc[7:0], then 8 shift-right steps. On each step, if the LSB before the shift is 1, XOR 16'hA001 after the shift.
  - One step per clock, so 8 cycles per byte.
  - The CRC covers bytes 0..N-3. The CRC bytes are sent low byte first.
- State machine:
  - IDLE: waits for `tx_req` with `resp_type` ≠ 3. On acceptance it latches the inputs, sets idx = 0, crc = FFFF and `busy` = 1, then goes to LOAD.
  - LOAD: drives `tx_data` = byte[idx] and pulses `tx_start` for one cycle. If idx < N-2, it starts folding the byte into the CRC. Then goes to WAIT.
  - WAIT: CRC steps run in parallel with the UART byte. On `tx_done` with the CRC fold complete, idx increments: if idx+1 < N go to LOAD, else go to GUARD.
    - If `tx_done` arrives before the fold completes, the pulse is remembered. The exit then occurs when the fold completes.
  - GUARD: counts GUARD_CYC = (CLK_FREQ/BAUD_RATE)*77/2 cycles in integer arithmetic; this is 16709 at the defaults. On expiry it pulses `frame_done`, drops `busy` and returns to IDLE.
- `tx_req` while `busy` is ignored, not queued.
- Stray `tx_done` in IDLE or GUARD is ignored.
- Reset at any point forces IDLE: the CRC and counters clear and no further `tx_start` is issued.

## Timing
- Reset values: `tx_start` = 0, `tx_data` = 8'h00, `busy` = 0, `frame_done` = 0.
- `tx_req` sampled at edge k: `busy` = 1 from k+1, and the first `tx_start` is high during cycle k+2.
- `tx_start` is high exactly one cycle per byte.
- `tx_data` is valid in the `tx_start` cycle and stays stable until the matching `tx_done`.
- The next byte's `tx_start` comes 2 cycles after `tx_done`: one cycle to WAIT-exit/increment, then LOAD.
- `frame_done` is asserted GUARD_CYC+1 cycles after the last `tx_done`. `busy` falls in the same cycle.
- A `tx_req` in the cycle that `frame_done` is asserted is ignored. The next request can be accepted from the following cycle.

## Test plan
- Write echo, func 8'h06, addr 16'h0001, data 16'h0005 -> UART bytes 01 06 00 01 00 05 18 09; exactly 8 `tx_start` pulses; one `frame_done`.
- Exception, func 8'h03, exc 8'h02 -> bytes 01 83 02 C0 F1; `busy` low exactly GUARD_CYC+1 cycles after the 5th `tx_done`.
- Read reply, func 8'h03, data 16'h0005 -> bytes 01 03 02 00 05 followed by the CRC from the bench reference model; loopback through `uart_byte_rx` and `modbus_crc` reports a matching CRC.
- Second `tx_req` pulsed mid-frame and during GUARD, with changed inputs -> ignored; the in-flight frame is unchanged; no extra bytes are sent.
- `resp_type` = 3, and stray `tx_done` pulses while IDLE -> no `tx_start`, `busy` stays 0.
- `rst_n_in` low for 1 cycle during byte 3 of a write echo -> all outputs return to their reset values. A subsequent exception request then produces a correct 5-byte frame with a fresh CRC.
